// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and queue entry type for the fetch stage
package fetch_queue_pkg;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;
    localparam int          IMEM_ADDR_W = 10;
    localparam logic [31:0] PC_STEP     = 32'd4;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory, redirect and decode-side signals of the fetch stage
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_rdata;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   stall;
    logic                   out_valid;
    logic [31:0]            out_instr;
    logic [31:0]            out_pc4;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc4,
        input  imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc4,
        output imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/fetchq_fifo.sv
// rtl/fetchq_fifo.sv - circular entry storage with push, pop, flush, head data and occupancy
module fetchq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  fq_entry_t wdata_i,
    output fq_entry_t head_o,
    output logic [PW:0] count_o
);

    fq_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
            else if (!push_i && pop_i) count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Push at full only happens together with a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC, prefetch queue and decode handoff; FETCHQ_BYPASS_EN enables empty-queue pass-through
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    fetch_queue_if.master   bus
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] next_pc;
    logic [PW:0] count;
    fq_entry_t   head;
    fq_entry_t   wdata;
    logic        nonempty;
    logic        bypass;
    logic        push, pop;
    logic        fifo_push, fifo_pop;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = rst && !nonempty && !bus.redirect;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        nonempty      = (count != '0);
        next_pc       = fetch_pc_q + PC_STEP;
        wdata.pc4     = next_pc;
        wdata.instr   = bus.imem_rdata;
        bus.imem_addr = fetch_pc_q[IMEM_ADDR_W+1:2];

        bus.out_valid = nonempty || bypass;
        bus.out_instr = INSTR_NOP;
        bus.out_pc4   = 32'h0;
        if (bypass) begin
            bus.out_instr = bus.imem_rdata;
            bus.out_pc4   = next_pc;
        end else if (nonempty) begin
            bus.out_instr = head.instr;
            bus.out_pc4   = head.pc4;
        end

        pop  = bus.out_valid && !bus.stall && !bus.redirect;
        push = !bus.redirect && ((count < FULL) || pop);
        // A bypassed word consumed by decode never enters storage.
        fifo_pop  = pop && nonempty;
        fifo_push = push && !(bypass && !bus.stall);

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        else if (push)    fetch_pc_d = next_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fetch_pc_q <= RESET_PC;
        else      fetch_pc_q <= fetch_pc_d;
    end

    fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (bus.redirect),
        .wdata_i (wdata),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_queue_if bus ();

    fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Memory word n holds 32'h1000_0000 + n.
    assign bus.imem_rdata = 32'h1000_0000 + {22'h0, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic stall_val);
        rst             = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall       = stall_val;
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        step(); step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", bus.out_instr); end
        checks++; if (bus.out_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", bus.out_pc4); end
        checks++; if (bus.imem_addr !== 10'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
    endtask

    task automatic test_stream();
        int w;
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            w = k - (BYP ? 0 : 1);
            checks++;
            if (bus.out_valid !== (w >= 0)) begin errors++; $display("FAIL stream_valid c%0d got %0b exp %0b", k, bus.out_valid, (w >= 0)); end
            if (w >= 0) begin
                checks++;
                if (bus.out_instr !== 32'h1000_0000 + w || bus.out_pc4 !== 32'(4 * (w + 1))) begin
                    errors++; $display("FAIL stream_data c%0d got %h/%h exp %h/%h", k, bus.out_instr, bus.out_pc4, 32'h1000_0000 + w, 4 * (w + 1));
                end
            end else begin
                checks++;
                if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL stream_empty_instr got %h exp 0", bus.out_instr); end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 10'h0) begin errors++; $display("FAIL async_reset got %0b/%h exp 0/0", bus.out_valid, bus.imem_addr); end
    endtask

    task automatic test_stall();
        do_reset(1'b1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0 || BYP) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1000_0000) begin errors++; $display("FAIL stall_hold c%0d got %0b/%h exp 1/10000000", c, bus.out_valid, bus.out_instr); end
            end
            step();
        end
        checks++; if (bus.imem_addr !== 10'd4) begin errors++; $display("FAIL stall_addr got %0d exp 4", bus.imem_addr); end
        step();
        checks++; if (bus.imem_addr !== 10'd4) begin errors++; $display("FAIL stall_addr_hold got %0d exp 4", bus.imem_addr); end
        bus.stall = 1'b0;
        #1;
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1000_0000 + j || bus.out_pc4 !== 32'(4 * (j + 1))) begin
                errors++; $display("FAIL drain w%0d got %0b/%h/%h exp 1/%h/%h", j, bus.out_valid, bus.out_instr, bus.out_pc4, 32'h1000_0000 + j, 4 * (j + 1));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        step(); step(); step();
        checks++; if (bus.imem_addr !== 10'd3) begin errors++; $display("FAIL redir_pre_addr got %0d exp 3", bus.imem_addr); end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0043; bus.stall = 1'b0;
        step();
        bus.redirect = 1'b0;
        #1;
        if (!BYP) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %0b exp 0", bus.out_valid); end
            checks++; if (bus.imem_addr !== 10'h10) begin errors++; $display("FAIL redir_addr got %h exp 010", bus.imem_addr); end
            step();
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc4 !== 32'h44 || bus.out_instr !== 32'h1000_0010) begin errors++; $display("FAIL redir_target got %0b/%h/%h exp 1/00000044/10000010", bus.out_valid, bus.out_pc4, bus.out_instr); end
        step();
        checks++; if (bus.out_pc4 !== 32'h48 || bus.out_instr !== 32'h1000_0011) begin errors++; $display("FAIL redir_next got %h/%h exp 00000048/10000011", bus.out_pc4, bus.out_instr); end
    endtask

    task automatic test_redirect_stall_full();
        do_reset(1'b1);
        repeat (6) step();
        checks++; if (bus.imem_addr !== 10'd4) begin errors++; $display("FAIL full_addr got %0d exp 4", bus.imem_addr); end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
        step();
        bus.redirect = 1'b0; bus.stall = 1'b0;
        #1;
        if (!BYP) begin
            checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 10'h80) begin errors++; $display("FAIL rs_flush got %0b/%h exp 0/080", bus.out_valid, bus.imem_addr); end
            step();
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc4 !== 32'h204 || bus.out_instr !== 32'h1000_0080) begin errors++; $display("FAIL rs_target got %0b/%h/%h exp 1/00000204/10000080", bus.out_valid, bus.out_pc4, bus.out_instr); end
    endtask

    task automatic test_pc_wrap();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        #1;
        if (!BYP) begin
            checks++; if (bus.imem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_addr got %h exp 3ff", bus.imem_addr); end
            step();
        end
        checks++; if (bus.out_pc4 !== 32'h0 || bus.out_instr !== 32'h1000_03FF || bus.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc4 got %0b/%h/%h exp 1/00000000/100003ff", bus.out_valid, bus.out_pc4, bus.out_instr); end
        checks++; if (bus.imem_addr !== (BYP ? 10'h3FF : 10'h0)) begin errors++; $display("FAIL wrap_fetch_pc got %h exp %h", bus.imem_addr, (BYP ? 10'h3FF : 10'h0)); end
        step();
        checks++; if (bus.out_pc4 !== 32'h4 || bus.out_instr !== 32'h1000_0000) begin errors++; $display("FAIL wrap_next got %h/%h exp 00000004/10000000", bus.out_pc4, bus.out_instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall = 1'b0;
        test_reset();
        test_stream();
        test_async_reset();
        test_stall();
        test_redirect();
        test_redirect_stall_full();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
